mem_port_arbiter: RTL and testbench

Shares the core's single-port unified memory between instruction fetch (IF) and the load/store data path (DM). It sits between the fetch unit, the memory stage (driven by the decoder's load/store classification), and the memory macro. It sequences one access at a time through a fixed-latency memory. Data accesses take priority, with a starvation guard for fetch and a flush that cancels an in-flight fetch result.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the memory stage and the unified memory macro.
// The arbiter takes the slave view; the surrounding core/environment takes the master view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs. load/store, one access in flight at a time
// through a fixed-latency memory. Data side has priority; fetch wins once after
// STARVE_LIMIT consecutive contested data grants. A flush discards a pending fetch result.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rstN,
    mem_port_arbiter_if.slave  bus
);

    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [31:0]         WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic                owner_dm;
    logic                store;
    logic                drop;
    logic [CNT_W-1:0]    cnt;
    logic [STARVE_W-1:0] starve;

    logic if_elig;
    logic pick_if;
    logic pick_dm;
    logic done;

    // Arbitration: a flushing fetch is never eligible; fetch beats data only when starved
    assign if_elig = bus.if_req && !bus.if_flush;
    assign pick_if = rstN && (state == IDLE) && if_elig && (!bus.dm_req || starve == STARVE_MAX);
    assign pick_dm = rstN && (state == IDLE) && bus.dm_req && !pick_if;
    assign done    = (state == WAIT) && (cnt == '0);

    assign bus.busy = (state == WAIT);

    // Grant-cycle memory strobes and completion-cycle read data, both combinational
    always_comb begin
        bus.if_gnt    = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'h0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = 32'h0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = 32'h0;

        if (pick_if) begin
            bus.if_gnt   = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_be   = 4'hF;
            bus.mem_addr = bus.if_addr & WORD_MASK;
        end else if (pick_dm) begin
            bus.dm_gnt    = 1'b1;
            bus.mem_req   = 1'b1;
            bus.mem_we    = bus.dm_we;
            bus.mem_be    = bus.dm_be;
            bus.mem_addr  = bus.dm_addr & WORD_MASK;
            bus.mem_wdata = bus.dm_wdata;
        end

        if (done) begin
            if (owner_dm) begin
                bus.dm_rvalid = 1'b1;
                bus.dm_rdata  = store ? 32'h0 : bus.mem_rdata;
            end else if (!drop && !bus.if_flush) begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.mem_rdata;
            end
        end
    end

    // Access sequencer: records the owner at grant, counts down the memory latency
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            owner_dm <= 1'b0;
            store    <= 1'b0;
            drop     <= 1'b0;
            cnt      <= '0;
            starve   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_if || pick_dm) begin
                        state    <= WAIT;
                        owner_dm <= pick_dm;
                        store    <= pick_dm && bus.dm_we;
                        drop     <= 1'b0;
                        cnt      <= CNT_INIT;
                    end
                    if (pick_if) begin
                        starve <= '0;
                    end else if (pick_dm && if_elig) begin
                        starve <= starve + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.if_flush && !owner_dm) begin
                        drop <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// starvation and reset-mid-access sequences, against a small fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int MEM_LATENCY  = 2;
    localparam int STARVE_LIMIT = 4;
    localparam logic        Y = 1'b1;
    localparam logic        N = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MEM_LATENCY (MEM_LATENCY),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    // Memory model: word array, byte-enabled writes, read data delayed MEM_LATENCY cycles
    logic [31:0] mem   [0:255];
    logic [31:0] rpipe [MEM_LATENCY];

    always @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[64] <= 32'h0000_0013;
            for (int i = 0; i < MEM_LATENCY; i++) rpipe[i] <= 32'h0;
        end else begin
            if (bus.mem_req && bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            rpipe[0] <= bus.mem_req ? mem[bus.mem_addr[9:2]] : 32'h0;
            for (int i = 1; i < MEM_LATENCY; i++) rpipe[i] <= rpipe[i-1];
        end
    end
    assign bus.mem_rdata = rpipe[MEM_LATENCY-1];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ifr;  logic [31:0] ia;  logic fl;
        logic        dmr;  logic we; logic [3:0] be; logic [31:0] da; logic [31:0] wd;
        logic        igt;  logic irv; logic [31:0] ird;
        logic        dgt;  logic drv; logic [31:0] drd;
        logic        mrq;  logic mwe; logic [3:0] mbe; logic [31:0] ma; logic [31:0] mwd;
        logic        bsy;
    } vec_t;

    vec_t vecs [0:39];
    int   nv = 0;

    task automatic add(
        input logic ifr, input logic [31:0] ia, input logic fl,
        input logic dmr, input logic we, input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
        input logic igt, input logic irv, input logic [31:0] ird,
        input logic dgt, input logic drv, input logic [31:0] drd,
        input logic mrq, input logic mwe, input logic [3:0] mbe, input logic [31:0] ma, input logic [31:0] mwd,
        input logic bsy);
        vecs[nv] = '{ifr, ia, fl, dmr, we, be, da, wd, igt, irv, ird, dgt, drv, drd,
                     mrq, mwe, mbe, ma, mwd, bsy};
        nv++;
    endtask

    function automatic logic [138:0] act();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata,
                bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.busy};
    endfunction

    function automatic logic [138:0] expv(input vec_t v);
        return {v.igt, v.irv, v.ird, v.dgt, v.drv, v.drd, v.mrq, v.mwe, v.mbe, v.ma, v.mwd, v.bsy};
    endfunction

    task automatic check(input string name, input logic [138:0] got, input logic [138:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ia, input logic fl,
                         input logic dmr, input logic we, input logic [3:0] be,
                         input logic [31:0] da, input logic [31:0] wd);
        bus.if_req   = ifr;
        bus.if_addr  = ia;
        bus.if_flush = fl;
        bus.dm_req   = dmr;
        bus.dm_we    = we;
        bus.dm_be    = be;
        bus.dm_addr  = da;
        bus.dm_wdata = wd;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 4 units after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int ng;
        logic if_done;
        logic [5:0] if_turn;

        // Lone fetch of 0x102 -> word 0x100 holding 0x13
        add(Y,32'h102,N, N,N,4'h0,Z,Z, Y,N,Z, N,N,Z, Y,N,4'hF,32'h100,Z, N);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,Y,32'h13, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, N);
        // Contention: load wins, fetch held and granted at T+3
        add(Y,32'h104,N, Y,N,4'hF,32'h200,Z, N,N,Z, Y,N,Z, Y,N,4'hF,32'h200,Z, N);
        add(Y,32'h104,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(Y,32'h104,N, N,N,4'h0,Z,Z, N,N,Z, N,Y,32'hA500_0080, N,N,4'h0,Z,Z, Y);
        add(Y,32'h104,N, N,N,4'h0,Z,Z, Y,N,Z, N,N,Z, Y,N,4'hF,32'h104,Z, N);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,Y,32'hA500_0041, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, N);
        // Store half-word to 0x300, then load it back
        add(N,Z,N, Y,Y,4'h3,32'h300,32'hDEAD_BEEF, N,N,Z, Y,N,Z, Y,Y,4'h3,32'h300,32'hDEAD_BEEF, N);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,Y,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, Y,N,4'hF,32'h300,Z, N,N,Z, Y,N,Z, Y,N,4'hF,32'h300,Z, N);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,Y,32'hA500_BEEF, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, N);
        // Flush during an in-flight fetch drops its result
        add(Y,32'h108,N, N,N,4'h0,Z,Z, Y,N,Z, N,N,Z, Y,N,4'hF,32'h108,Z, N);
        add(N,Z,Y, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        // Request with flush in IDLE: no fetch grant, data still granted
        add(Y,32'h108,Y, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, N);
        add(Y,32'h108,Y, Y,N,4'hF,32'h200,Z, N,N,Z, Y,N,Z, Y,N,4'hF,32'h200,Z, N);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,Y, N,N,4'h0,Z,Z, N,N,Z, N,Y,32'hA500_0080, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, N);
        // Flush exactly in the fetch completion cycle
        add(Y,32'h100,N, N,N,4'h0,Z,Z, Y,N,Z, N,N,Z, Y,N,4'hF,32'h100,Z, N);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,Y, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, Y);
        add(N,Z,N, N,N,4'h0,Z,Z, N,N,Z, N,N,Z, N,N,4'h0,Z,Z, N);

        // Reset held with requests present: every output stays 0
        rstN = 1'b0;
        drive(Y, 32'h100, N, Y, N, 4'hF, 32'h200, Z);
        repeat (3) @(posedge clk);
        #4;
        check("reset_held", act(), '0);

        // First cycle after release with no request
        step();
        drive(N, Z, N, N, N, 4'h0, Z, Z);
        rstN = 1'b1;
        #3;
        check("reset_release", act(), '0);

        for (int i = 0; i < nv; i++) begin
            step();
            drive(vecs[i].ifr, vecs[i].ia, vecs[i].fl, vecs[i].dmr, vecs[i].we,
                  vecs[i].be, vecs[i].da, vecs[i].wd);
            #3;
            check($sformatf("vec%0d", i), act(), expv(vecs[i]));
        end

        // Starvation: fetch held against back-to-back loads -> D D D D I D
        ng      = 0;
        if_done = 1'b0;
        if_turn = 6'b01_0000;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            step();
            drive(!if_done, 32'h10C, N, Y, N, 4'hF, 32'h200, Z);
            #3;
            if (bus.if_gnt || bus.dm_gnt) begin
                check($sformatf("starve_grant%0d", ng), 139'({bus.if_gnt, bus.dm_gnt}),
                      if_turn[ng] ? 139'(2'b10) : 139'(2'b01));
                if (bus.if_gnt) begin
                    check("starve_if_addr", 139'(bus.mem_addr), 139'(32'h10C));
                    if_done = 1'b1;
                end
                ng++;
            end
        end
        if (ng < 6) begin
            checks++;
            errors++;
            $display("FAIL starve_timeout: got %0d grants expected 6", ng);
        end
        step();
        drive(N, Z, N, N, N, 4'h0, Z, Z);
        repeat (3) step();

        // Reset in the middle of a load: no completion, outputs 0, then immediate fetch grant
        drive(N, Z, N, Y, N, 4'hF, 32'h200, Z);
        #3;
        check("rst_mid_dm_gnt", 139'(bus.dm_gnt), 139'(1'b1));
        step();
        drive(N, Z, N, N, N, 4'h0, Z, Z);
        rstN = 1'b0;
        #3;
        check("rst_mid_t1", act(), '0);
        step();
        #3;
        check("rst_mid_t2", act(), '0);
        step();
        rstN = 1'b1;
        #3;
        check("rst_mid_release", act(), '0);
        step();
        drive(Y, 32'h100, N, N, N, 4'h0, Z, Z);
        #3;
        check("rst_after_if_gnt", 139'({bus.if_gnt, bus.mem_req, bus.mem_addr}),
              139'({Y, Y, 32'h100}));
        step();
        drive(N, Z, N, N, N, 4'h0, Z, Z);
        #3;
        check("rst_after_busy", 139'({bus.busy, bus.if_rvalid}), 139'(2'b10));
        step();
        #3;
        check("rst_after_rvalid", 139'({bus.if_rvalid, bus.if_rdata}), 139'({Y, 32'h13}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
